// File: rtl/parser_stream_ctrl.sv
// Shares one if/else statement parser among N_REQ character streams, one statement per grant.
// Define PARSER_STREAM_CTRL_STATS_EN to add saturating statement/error/timeout counters.
module parser_stream_ctrl #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [6:0]  TERM_CHAR = 7'h3B,
    localparam int unsigned ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [7*N_REQ-1:0]      req_char,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [DATA_W*N_REQ-1:0] req_x,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    prs_rst,
    output logic [6:0]              prs_char,
    output logic                    prs_char_valid,
    output logic [DATA_W-1:0]       prs_x,
    input  logic [DATA_W-1:0]       prs_p,
    input  logic                    prs_done,
    input  logic                    prs_error,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_p,
    output logic                    rsp_error,
    output logic                    rsp_timeout
`ifdef PARSER_STREAM_CTRL_STATS_EN
    ,
    output logic [15:0]             stat_stmts,
    output logic [15:0]             stat_errors,
    output logic [15:0]             stat_timeouts
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {StIdle, StGrant, StStream, StFlush, StWaitDone, StRespond} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    gnt_q, gnt_d, rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_seen_q, err_seen_d;
    logic               prs_rst_q, prs_rst_d;
    logic [6:0]         prs_char_q, prs_char_d;
    logic               prs_char_valid_q, prs_char_valid_d;
    logic [DATA_W-1:0]  prs_x_q, prs_x_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_p_q, rsp_p_d;
    logic               rsp_error_q, rsp_error_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic               found;
    int                 idx;
    logic [6:0]         cur_char;
    logic               err_now;

    always_comb begin
        state_d          = state_q;
        gnt_d            = gnt_q;
        rr_d             = rr_q;
        cnt_d            = cnt_q;
        err_seen_d       = err_seen_q;
        prs_char_d       = prs_char_q;
        prs_char_valid_d = 1'b0;
        prs_x_d          = prs_x_q;
        rsp_valid_d      = rsp_valid_q;
        rsp_id_d         = rsp_id_q;
        rsp_p_d          = rsp_p_q;
        rsp_error_d      = rsp_error_q;
        rsp_timeout_d    = rsp_timeout_q;
        found            = 1'b0;
        idx              = 0;
        cur_char         = req_char[7*int'(gnt_q) +: 7];
        err_now          = err_seen_q | prs_error;

        unique case (state_q)
            StIdle: begin
                // First requester at or after rr_q, wrapping
                for (int k = 0; k < int'(N_REQ); k++) begin
                    if (!found && req_valid[(int'(rr_q) + k) % int'(N_REQ)]) begin
                        found = 1'b1;
                        idx   = (int'(rr_q) + k) % int'(N_REQ);
                    end
                end
                if (found) begin
                    gnt_d   = ID_W'(idx);
                    state_d = StGrant;
                end
            end
            StGrant: begin
                prs_x_d    = req_x[DATA_W*int'(gnt_q) +: DATA_W];
                err_seen_d = 1'b0;
                state_d    = StStream;
            end
            StStream: begin
                err_seen_d = err_now;
                if (req_valid[gnt_q]) begin
                    // After an error the rest of the statement is drained, not forwarded
                    prs_char_d       = cur_char;
                    prs_char_valid_d = !err_now;
                    if (req_last[gnt_q]) state_d = StFlush;
                end
            end
            StFlush: begin
                err_seen_d       = err_now;
                prs_char_d       = TERM_CHAR;
                prs_char_valid_d = !err_now;
                cnt_d            = '0;
                state_d          = StWaitDone;
            end
            StWaitDone: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (err_now || prs_done || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = gnt_q;
                    rsp_error_d   = err_now;
                    rsp_timeout_d = !err_now && !prs_done;
                    rsp_p_d       = (!err_now && prs_done) ? prs_p : '0;
                    state_d       = StRespond;
                end
            end
            StRespond: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_d        = (gnt_q == ID_W'(N_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        prs_rst_d = (state_d == StGrant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q            <= '0;
            rr_q             <= '0;
            cnt_q            <= '0;
            err_seen_q       <= 1'b0;
            prs_rst_q        <= 1'b1;
            prs_char_q       <= '0;
            prs_char_valid_q <= 1'b0;
            prs_x_q          <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_id_q         <= '0;
            rsp_p_q          <= '0;
            rsp_error_q      <= 1'b0;
            rsp_timeout_q    <= 1'b0;
        end else begin
            gnt_q            <= gnt_d;
            rr_q             <= rr_d;
            cnt_q            <= cnt_d;
            err_seen_q       <= err_seen_d;
            prs_rst_q        <= prs_rst_d;
            prs_char_q       <= prs_char_d;
            prs_char_valid_q <= prs_char_valid_d;
            prs_x_q          <= prs_x_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_id_q         <= rsp_id_d;
            rsp_p_q          <= rsp_p_d;
            rsp_error_q      <= rsp_error_d;
            rsp_timeout_q    <= rsp_timeout_d;
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StStream) req_ready[gnt_q] = 1'b1;
    end

    assign prs_rst        = prs_rst_q;
    assign prs_char       = prs_char_q;
    assign prs_char_valid = prs_char_valid_q;
    assign prs_x          = prs_x_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_p          = rsp_p_q;
    assign rsp_error      = rsp_error_q;
    assign rsp_timeout    = rsp_timeout_q;

`ifdef PARSER_STREAM_CTRL_STATS_EN
    logic [15:0] stat_stmts_q, stat_errors_q, stat_timeouts_q;
    logic        hs;

    assign hs = (state_q == StRespond) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stmts_q    <= '0;
            stat_errors_q   <= '0;
            stat_timeouts_q <= '0;
        end else if (hs) begin
            if (stat_stmts_q != 16'hFFFF) stat_stmts_q <= stat_stmts_q + 16'd1;
            if (rsp_error_q && stat_errors_q != 16'hFFFF) stat_errors_q <= stat_errors_q + 16'd1;
            if (rsp_timeout_q && stat_timeouts_q != 16'hFFFF) begin
                stat_timeouts_q <= stat_timeouts_q + 16'd1;
            end
        end
    end

    assign stat_stmts    = stat_stmts_q;
    assign stat_errors   = stat_errors_q;
    assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_parser_stream_ctrl.sv
// Directed bench for parser_stream_ctrl with a behavioural if/else parser stub and
// char/response scoreboards.
module tb_parser_stream_ctrl;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] p;
        logic        err;
        logic        to;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [7*N-1:0]  req_char = '0;
    logic [N-1:0]    req_last = '0;
    logic [DW*N-1:0] req_x = '0;
    logic [N-1:0]    req_ready;
    logic            prs_rst;
    logic [6:0]      prs_char;
    logic            prs_char_valid;
    logic [DW-1:0]   prs_x;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [0:0]      rsp_id;
    logic [DW-1:0]   rsp_p;
    logic            rsp_error;
    logic            rsp_timeout;

    logic [7:0]      sbuf [64];
    int              slen;
    logic            stub_done, stub_err;
    logic            stub_hang = 1'b0;
    logic [6:0]      stub_prev;
    logic [31:0]     stub_p;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   term_cyc = 0;
    int   rst_hi_cnt = 0;
    int   fwd_cnt = 0;
    bit   abort = 1'b0;
    logic [6:0] exp_chars [$];
    rsp_t       exp_rsp [$];

    parser_stream_ctrl #(
        .N_REQ   (N),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_char       (req_char),
        .req_last       (req_last),
        .req_x          (req_x),
        .req_ready      (req_ready),
        .prs_rst        (prs_rst),
        .prs_char       (prs_char),
        .prs_char_valid (prs_char_valid),
        .prs_x          (prs_x),
        .prs_p          (stub_p),
        .prs_done       (stub_done),
        .prs_error      (stub_err),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_p          (rsp_p),
        .rsp_error      (rsp_error),
        .rsp_timeout    (rsp_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t mk(input int id, input int p, input bit err, input bit to);
        rsp_t r;
        r.id  = 8'(id);
        r.p   = 32'(p);
        r.err = err;
        r.to  = to;
        return r;
    endfunction

    // Digit runs in order: threshold, then-value, else-value
    function automatic int eval_stmt(input int n, input logic [31:0] x);
        int nums [3];
        int k;
        bit in_num;
        nums = '{0, 0, 0};
        k = -1;
        in_num = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (sbuf[i] >= 8'h30 && sbuf[i] <= 8'h39) begin
                if (!in_num) k++;
                in_num = 1'b1;
                if (k >= 0 && k < 3) nums[k] = nums[k] * 10 + int'(sbuf[i]) - 48;
            end else begin
                in_num = 1'b0;
            end
        end
        return (int'(x) > nums[0]) ? nums[1] : nums[2];
    endfunction

    // Parser stub: sticky error on '=' not preceded by '<'; done on ';' unless hung
    always @(posedge clk) begin
        if (prs_rst) begin
            slen      <= 0;
            stub_done <= 1'b0;
            stub_err  <= 1'b0;
            stub_prev <= '0;
            stub_p    <= '0;
        end else if (prs_char_valid) begin
            if (prs_char == 7'h3B) begin
                if (!stub_hang) begin
                    stub_done <= 1'b1;
                    stub_p    <= 32'(eval_stmt(slen, prs_x));
                end
            end else begin
                sbuf[slen[5:0]] <= {1'b0, prs_char};
                slen <= slen + 1;
                if (prs_char == 7'h3D && stub_prev != 7'h3C) stub_err <= 1'b1;
                stub_prev <= prs_char;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        logic [6:0] c;
        rsp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (prs_rst) rst_hi_cnt++;
            if (prs_char_valid) begin
                fwd_cnt++;
                if (prs_char == 7'h3B) term_cyc = cyc;
                if (exp_chars.size() == 0) begin
                    chk("char_unexpected", 64'(exp_chars.size()), 64'd1);
                end else begin
                    c = exp_chars.pop_front();
                    chk("char", 64'(prs_char), 64'(c));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", 64'(exp_rsp.size()), 64'd1);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_p", 64'(rsp_p), 64'(e.p));
                    chk("rsp_error", 64'(rsp_error), 64'(e.err));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                end
            end
        end
    end

    // nfwd < 0: every char plus the terminator is expected at the parser; else only the first nfwd
    task automatic send(input int r, input string s, input int x, input int nfwd);
        byte b;
        int  n;
        bit  stop;
        stop = 1'b0;
        req_x[r*DW +: DW] = 32'(x);
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            req_valid[r] = 1'b1;
            req_char[r*7 +: 7] = b[6:0];
            req_last[r] = (i == s.len() - 1);
            n = 0;
            @(negedge clk);
            while (!req_ready[r] && !abort && n < 4000) begin
                @(negedge clk);
                n++;
            end
            if (abort || n >= 4000) begin
                if (!abort) chk("send_stall", 64'(n), 64'd0);
                stop = 1'b1;
                break;
            end
            if (nfwd < 0 || i < nfwd) exp_chars.push_back(b[6:0]);
            if (nfwd < 0 && i == s.len() - 1) exp_chars.push_back(7'h3B);
            @(posedge clk);
            #1;
        end
        if (stop || !stop) begin
            req_valid[r] = 1'b0;
            req_last[r]  = 1'b0;
        end
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (exp_rsp.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(exp_rsp.size()), 64'd0);
        chk({tag, "_chars"}, 64'(exp_chars.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        string s1, s3, se;
        int base, fbase, n;
        s1 = "if x>5 p<=10 else p<=20";
        s3 = "if x>8 p<=4 else p<=6";
        se = "if x=5 p<=1 else p<=2";

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_prs_rst", 64'(prs_rst), 64'd1);
        chk("rst_prs_char", 64'(prs_char), 64'd0);
        chk("rst_prs_char_valid", 64'(prs_char_valid), 64'd0);
        chk("rst_prs_x", 64'(prs_x), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_fields", 64'({rsp_id, rsp_p, rsp_error, rsp_timeout}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_prs_rst", 64'(prs_rst), 64'd0);
        @(posedge clk);
        #1;

        // Single statement from requester 0
        base  = rst_hi_cnt;
        fbase = fwd_cnt;
        exp_rsp.push_back(mk(0, 10, 1'b0, 1'b0));
        send(0, s1, 7, -1);
        wait_rsp("req0_stmt");
        chk("prs_rst_pulses", 64'(rst_hi_cnt - base), 64'd1);
        chk("fwd_count", 64'(fwd_cnt - fbase), 64'(s1.len() + 1));

        // Same statement from requester 1
        exp_rsp.push_back(mk(1, 20, 1'b0, 1'b0));
        send(1, s1, 3, -1);
        wait_rsp("req1_stmt");

        // Contention: 0 then 1 even though 0 re-requests at once, then 0 again
        exp_rsp.push_back(mk(0, 10, 1'b0, 1'b0));
        exp_rsp.push_back(mk(1, 20, 1'b0, 1'b0));
        exp_rsp.push_back(mk(0, 4, 1'b0, 1'b0));
        fork
            begin
                send(0, s1, 7, -1);
                send(0, s3, 9, -1);
            end
            send(1, s1, 3, -1);
        join
        wait_rsp("arb");

        // Parser error mid-stream: chars through the one after '=' reach the parser
        exp_rsp.push_back(mk(0, 0, 1'b1, 1'b0));
        send(0, se, 5, 6);
        wait_rsp("err");

        // Timeout with a hung parser, response held under back-pressure
        stub_hang = 1'b1;
        rsp_ready = 1'b0;
        exp_rsp.push_back(mk(0, 0, 1'b0, 1'b1));
        send(0, s1, 7, -1);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("to_latency", 64'(cyc - term_cyc), 64'(TO));
        for (int i = 0; i < 5; i++) begin
            chk("to_hold", 64'({rsp_valid, rsp_id, rsp_p, rsp_error, rsp_timeout}),
                64'({1'b1, 1'b0, 32'd0, 1'b0, 1'b1}));
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_rsp("to");
        stub_hang = 1'b0;

        // Reset in the middle of a statement
        fbase = fwd_cnt;
        fork
            send(0, s1, 7, -1);
        join_none
        n = 0;
        while (fwd_cnt < fbase + 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_prs_rst", 64'(prs_rst), 64'd1);
        chk("midrst_char_valid", 64'(prs_char_valid), 64'd0);
        repeat (3) @(negedge clk);
        exp_chars.delete();
        abort = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        exp_rsp.push_back(mk(0, 20, 1'b0, 1'b0));
        send(0, s1, 2, -1);
        wait_rsp("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
